cla_serial_add32: RTL and testbench

Nibble-serial 32-bit adder that reuses one 4-bit carry-lookahead slice over eight cycles. The slice computes sum bits from the nibble generate/propagate terms and the lookahead carries `c1`–`c3` and `co`. The block sits downstream of the carry-lookahead logic: it registers the slice's `co` as the carry-in for the next nibble, and uses `c3` of the top nibble for signed overflow. It presents a start/done handshake to the datapath controller.

---
 rtl/cla_serial_add32.sv | 123 ++++++++++++
 tb/tb_cla_serial_add32.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_add32.sv
// Nibble-serial 32-bit adder built around one 4-bit carry-lookahead slice.
// The slice is reused over eight RUN cycles, least significant nibble first.
// The slice carry-out is registered as the carry-in for the next nibble.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   reset_n  - synchronous active-low reset
//   start    - request an add (accepted when idle or in the done cycle)
//   a, b     - 32-bit operands, captured on the accepting edge
//   ci       - carry-in to nibble 0, captured on the accepting edge
//   busy     - high while an operation is running or completing
//   done     - one-cycle pulse; s/co/ovf are valid from this cycle on
//   s        - sum a + b + ci mod 2^32, held until the next completion
//   co       - carry out of bit 31
//   ovf      - signed overflow (carry into bit 31 ^ carry out of bit 31)
module cla_serial_add32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        co,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic [31:0] a_sr, b_sr, sum_sr;
  logic        carry;
  logic [2:0]  k;

  logic [3:0]  g, p, nib_sum;
  logic        c1, c2, c3, c4;

  // The done cycle also samples start so that back-to-back operations
  // complete every 9 cycles.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (k == 3'd7) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // 4-bit carry-lookahead slice on the current low nibble of the operands.
  always_comb begin
    g  = a_sr[3:0] & b_sr[3:0];
    p  = a_sr[3:0] ^ b_sr[3:0];
    c1 = g[0] | (p[0] & carry);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & carry);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]) | (&p & carry);
    nib_sum = p ^ {c3, c2, c1, carry};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      k      <= '0;
      s      <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        carry  <= ci;
        k      <= '0;
        sum_sr <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 4;
        b_sr   <= b_sr >> 4;
        carry  <= c4;
        k      <= k + 3'd1;
        sum_sr <= {nib_sum, sum_sr[31:4]};
        if (k == 3'd7) begin
          s   <= {nib_sum, sum_sr[31:4]};
          co  <= c4;
          ovf <= c3 ^ c4;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_add32.sv
// Self-checking bench for cla_serial_add32: table-driven vectors (fixed
// corner cases plus random operands scored against a plain-arithmetic
// reference), followed by hand-written multi-cycle sequences.
module tb_cla_serial_add32;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        ci_in;
  logic        busy, done;
  logic [31:0] s;
  logic        co, ovf;

  int compared;
  int mismatched;

  cla_serial_add32 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
    .ci     (ci_in),
    .busy   (busy),
    .done   (done),
    .s      (s),
    .co     (co),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] es;
    logic        eco;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } res_t;

  // Reference: full-width arithmetic; overflow from operand/result signs.
  function automatic res_t ref_add(input logic [31:0] x, input logic [31:0] y,
                                   input logic c);
    res_t r;
    logic [32:0] wide;
    wide  = {1'b0, x} + {1'b0, y} + {32'd0, c};
    r.s   = wide[31:0];
    r.co  = wide[32];
    r.ovf = (x[31] == y[31]) && (wide[31] != x[31]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Accept one operation, optionally scramble inputs while running, and
  // wait (bounded) for done. lat = cycles from accept edge to done, -1 if none.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                        input bit scramble, output int lat);
    a_in  = x;
    b_in  = y;
    ci_in = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (scramble) begin
        a_in  = $urandom;
        b_in  = $urandom;
        ci_in = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t        tbl[12];
  int          lat;
  int          dcount;
  logic [31:0] saved_s;
  logic [31:0] prev_s;
  logic        saved_co, saved_ovf;
  res_t        r;
  res_t        held_exp[3];
  bit          stable;
  int          since;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    a_in       = '0;
    b_in       = '0;
    ci_in      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s",    s,          32'd0);
    chk("reset_co",   32'(co),   32'd0);
    chk("reset_ovf",  32'(ovf),  32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: fixed corners then random operands.
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[3] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    for (int i = 4; i < 12; i++) begin
      tbl[i].a  = $urandom;
      tbl[i].b  = $urandom;
      tbl[i].ci = 1'($urandom_range(0, 1));
      r = ref_add(tbl[i].a, tbl[i].b, tbl[i].ci);
      tbl[i].es   = r.s;
      tbl[i].eco  = r.co;
      tbl[i].eovf = r.ovf;
    end

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b1, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_s", i),   s,          tbl[i].es);
      chk($sformatf("vec%0d_co", i),  32'(co),   32'(tbl[i].eco));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf),  32'(tbl[i].eovf));
      chk($sformatf("vec%0d_busy_in_done", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_s_hold", i),     s,          tbl[i].es);
    end

    // start pulses during RUN are ignored
    r = ref_add(32'hCAFEBABE, 32'h01234567, 1'b0);
    a_in  = 32'hCAFEBABE;
    b_in  = 32'h01234567;
    ci_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    dcount = 0;
    saved_s = '0;
    saved_co = 1'b0;
    saved_ovf = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 3 || n == 6) begin
        start = 1'b1;
        a_in  = $urandom;
        b_in  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        saved_s   = s;
        saved_co  = co;
        saved_ovf = ovf;
      end
    end
    start = 1'b0;
    chk("ignore_start_done_count", 32'(dcount), 32'd1);
    chk("ignore_start_s",   saved_s,         r.s);
    chk("ignore_start_co",  32'(saved_co),  32'(r.co));
    chk("ignore_start_ovf", 32'(saved_ovf), 32'(r.ovf));

    // Reset in the middle of a run
    a_in  = 32'hFFFFFFFF;
    b_in  = 32'h00000001;
    ci_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_s",    s,          32'd0);
    chk("midreset_co",   32'(co),   32'd0);
    reset_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midreset_no_done", 32'(dcount), 32'd0);
    run_op(32'd5, 32'd3, 1'b0, 1'b0, lat);
    chk("after_reset_latency", 32'(lat), 32'd8);
    chk("after_reset_s",       s,          32'd8);
    @(posedge clk);
    #1;

    // start held high: three back-to-back operations
    for (int i = 0; i < 3; i++) begin
      held_exp[i].s = 0;
    end
    a_in  = $urandom;
    b_in  = $urandom;
    ci_in = 1'($urandom_range(0, 1));
    held_exp[0] = ref_add(a_in, b_in, ci_in);
    start = 1'b1;
    @(posedge clk);
    #1;
    prev_s = s;
    for (int op = 0; op < 3; op++) begin
      since  = -1;
      stable = 1'b1;
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk);
        #1;
        if (done) begin
          since = n;
          break;
        end
        if (s !== prev_s) stable = 1'b0;
      end
      chk($sformatf("held%0d_period", op), 32'(since), (op == 0) ? 32'd8 : 32'd9);
      chk($sformatf("held%0d_s_stable_run", op), 32'(stable), 32'd1);
      chk($sformatf("held%0d_s", op),   s,          held_exp[op].s);
      chk($sformatf("held%0d_co", op),  32'(co),   32'(held_exp[op].co));
      chk($sformatf("held%0d_ovf", op), 32'(ovf),  32'(held_exp[op].ovf));
      prev_s = s;
      if (op < 2) begin
        a_in  = $urandom;
        b_in  = $urandom;
        ci_in = 1'($urandom_range(0, 1));
        held_exp[op + 1] = ref_add(a_in, b_in, ci_in);
      end else begin
        start = 1'b0;
      end
    end
    stable = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (s !== held_exp[2].s || busy !== 1'b0) stable = 1'b0;
    end
    chk("held_idle_stable", 32'(stable), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
